// File: rtl/laser_pkg.sv
// Shared types and constants for the LASER two-circle search scheduler.
// The optional early-exit feature is controlled by LASER_EARLY_EXIT_EN.
package laser_pkg;

   localparam int GRID_W = 4;
   localparam int CNT_W  = 6;
   localparam int NPTS   = 40;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SCAN,
      S_WAIT,
      S_PASS_END,
      S_FINISH
   } state_t;

   typedef struct packed {
      logic [GRID_W-1:0] x;
      logic [GRID_W-1:0] y;
   } pt_t;

   localparam pt_t C1_INIT = '{x: 4'd4, y: 4'd4};
   localparam pt_t C2_INIT = '{x: 4'd11, y: 4'd11};

endpackage

// File: rtl/laser_search_ctrl_if.sv
// Candidate request / coverage result channel between the search
// scheduler (master) and the shared coverage-count engine (slave).
interface laser_search_ctrl_if;
   import laser_pkg::*;

   logic              cand_valid;
   logic              cand_ready;
   logic [GRID_W-1:0] cand_x;
   logic [GRID_W-1:0] cand_y;
   logic [GRID_W-1:0] fix_x;
   logic [GRID_W-1:0] fix_y;
   logic              res_valid;
   logic [CNT_W-1:0]  res_cnt;

   modport master (
      output cand_valid, cand_x, cand_y, fix_x, fix_y,
      input  cand_ready, res_valid, res_cnt
   );

   modport slave (
      input  cand_valid, cand_x, cand_y, fix_x, fix_y,
      output cand_ready, res_valid, res_cnt
   );

endinterface

// File: rtl/laser_raster_gen.sv
// Raster candidate generator: x inner, y outer, wraps (15,15) -> (0,0).
module laser_raster_gen
   import laser_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              clr,
   input  logic              adv,
   output logic [GRID_W-1:0] x,
   output logic [GRID_W-1:0] y,
   output logic              last
);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         x <= '0;
         y <= '0;
      end else if (adv) begin
         x <= x + 1'b1;
         if (&x) y <= y + 1'b1;
      end
   end

   assign last = (&x) & (&y);

endmodule

// File: rtl/laser_search_ctrl.sv
// Alternating-pass search scheduler for the LASER two-circle problem.
// Define LASER_EARLY_EXIT_EN to stop as soon as a full count is seen.
module laser_search_ctrl
   import laser_pkg::*;
#(
   parameter int MAX_ITER = 4
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                start,
   output logic                busy,
   laser_search_ctrl_if.master eng,
   output logic [GRID_W-1:0]   C1X,
   output logic [GRID_W-1:0]   C1Y,
   output logic [GRID_W-1:0]   C2X,
   output logic [GRID_W-1:0]   C2Y,
   output logic                DONE
);

   localparam int IT_W = $clog2(MAX_ITER + 1);

   state_t           state, nxt;
   pt_t              c1, c2, pos, cand;
   logic [CNT_W-1:0] g_best, p_best;
   logic [IT_W-1:0]  iter;
   logic             pass2, r_imp;
   logic             rclr, radv, rlast;
   logic [GRID_W-1:0] rx, ry;

   logic acc, got, imp, ri, it_last;

   assign acc     = eng.cand_valid & eng.cand_ready;
   assign got     = (state == S_WAIT) & eng.res_valid;
   assign imp     = p_best > g_best;
   assign ri      = r_imp | imp;
   assign it_last = iter == IT_W'(MAX_ITER - 1);
   assign cand    = '{x: rx, y: ry};

`ifdef LASER_EARLY_EXIT_EN
   logic full;
   assign full = got & (eng.res_cnt == CNT_W'(NPTS));
`endif

   laser_raster_gen u_raster (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (rclr),
      .adv  (radv),
      .x    (rx),
      .y    (ry),
      .last (rlast)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:  if (start) nxt = S_INIT;
         S_INIT:  nxt = S_SCAN;
         S_SCAN:  if (acc) nxt = S_WAIT;
         S_WAIT: begin
            if (got) begin
               if (rlast) nxt = S_PASS_END;
               else       nxt = S_SCAN;
`ifdef LASER_EARLY_EXIT_EN
               if (full)  nxt = S_FINISH;
`endif
            end
         end
         S_PASS_END: begin
            if (pass2 && (!ri || it_last)) nxt = S_FINISH;
            else                           nxt = S_SCAN;
         end
         S_FINISH: nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
   end

   always_comb begin
      eng.cand_valid = (state == S_SCAN);
      eng.cand_x     = rx;
      eng.cand_y     = ry;
      eng.fix_x      = pass2 ? c1.x : c2.x;
      eng.fix_y      = pass2 ? c1.y : c2.y;
      busy           = (state != S_IDLE) && (state != S_FINISH);
      DONE           = (state == S_FINISH);
      C1X            = c1.x;
      C1Y            = c1.y;
      C2X            = c2.x;
      C2Y            = c2.y;
      rclr           = (state == S_INIT) || (state == S_PASS_END);
      radv           = got && !rlast;
   end

   // pass_best only ever rises from global_best, so it already holds the
   // correct starting value for the next pass without a reload.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         c1     <= '0;
         c2     <= '0;
         pos    <= '0;
         g_best <= '0;
         p_best <= '0;
         iter   <= '0;
         pass2  <= 1'b0;
         r_imp  <= 1'b0;
      end else begin
         unique case (state)
            S_INIT: begin
               c1     <= C1_INIT;
               c2     <= C2_INIT;
               g_best <= '0;
               p_best <= '0;
               iter   <= '0;
               pass2  <= 1'b0;
               r_imp  <= 1'b0;
            end
            S_WAIT: begin
               if (got && eng.res_cnt > p_best) begin
                  p_best <= eng.res_cnt;
                  pos    <= cand;
               end
`ifdef LASER_EARLY_EXIT_EN
               if (full) begin
                  g_best <= eng.res_cnt;
                  if (pass2) c2 <= cand;
                  else       c1 <= cand;
               end
`endif
            end
            S_PASS_END: begin
               if (imp) begin
                  g_best <= p_best;
                  if (pass2) c2 <= pos;
                  else       c1 <= pos;
               end
               if (!pass2) begin
                  pass2 <= 1'b1;
                  r_imp <= ri;
               end else begin
                  iter  <= iter + 1'b1;
                  pass2 <= 1'b0;
                  r_imp <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_laser_search_ctrl.sv
// Scoreboard bench for laser_search_ctrl with a scripted coverage engine.
module tb_laser_search_ctrl;
   import laser_pkg::*;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              start = 1'b0;
   logic              busy, DONE;
   logic [GRID_W-1:0] C1X, C1Y, C2X, C2Y;

   laser_search_ctrl_if eng ();

   laser_search_ctrl #(.MAX_ITER(4)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .start (start),
      .busy  (busy),
      .eng   (eng),
      .C1X   (C1X),
      .C1Y   (C1Y),
      .C2X   (C2X),
      .C2Y   (C2Y),
      .DONE  (DONE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string nm;
      int    c1x, c1y, c2x, c2y, ncand;
   } exp_t;

   exp_t sbq[$];
   int   pass_n = 0;
   int   tot_n  = 0;
   int   mode   = 0;
   int   ncand  = 0;
   int   dones  = 0;
   bit   stall_done = 1'b0;

   task automatic chk(string nm, int act, int exp);
      tot_n++;
      if (act == exp) pass_n++;
      else $display("FAIL %s: got %0d want %0d", nm, act, exp);
   endtask

   // Scripted engine responses per test mode and global pass index.
   function automatic int resp(int m, int p, int x, int y);
      case (m)
         1: return 5;
         2: begin
            if (p % 2 == 0 && x == 7 && y == 3)  return 10;
            if (p % 2 == 1 && x == 9 && y == 12) return 12;
            return 0;
         end
         3: return (p % 2 == 0 && x == 2 && y == 2) ? 40 : 0;
         4: return p + 1;
         default: return 0;
      endcase
   endfunction

   initial begin : engine
      bit pend;
      int px, py, pidx, stall;
      pend = 0;
      stall = 0;
      eng.cand_ready = 1'b0;
      eng.res_valid  = 1'b0;
      eng.res_cnt    = '0;
      forever begin
         @(negedge CLK);
         eng.res_valid  = 1'b0;
         eng.res_cnt    = '0;
         eng.cand_ready = 1'b1;
         if (RST) begin
            pend = 0;
            stall = 0;
         end else if (pend) begin
            eng.res_valid = 1'b1;
            eng.res_cnt   = CNT_W'(resp(mode, pidx, px, py));
            pend = 0;
         end else if (eng.cand_valid) begin
            if (mode == 2 && !stall_done && stall == 0 &&
                eng.cand_x == 5 && eng.cand_y == 0) begin
               stall = 3;
               stall_done = 1'b1;
            end
            if (stall > 0) begin
               eng.cand_ready = 1'b0;
               if (stall < 3) begin
                  chk("stall_valid", eng.cand_valid, 1);
                  chk("stall_cx", eng.cand_x, 5);
                  chk("stall_cy", eng.cand_y, 0);
                  chk("stall_fx", eng.fix_x, 11);
                  chk("stall_fy", eng.fix_y, 11);
               end
               // a bogus strobe outside WAIT must be ignored
               eng.res_valid = 1'b1;
               eng.res_cnt   = 6'd63;
               stall--;
            end else begin
               pidx = ncand / 256;
               px   = eng.cand_x;
               py   = eng.cand_y;
               ncand++;
               pend = 1;
               if (mode == 2) begin
                  eng.res_valid = 1'b1;
                  eng.res_cnt   = 6'd63;
               end
            end
         end
      end
   end

   initial begin : monitor
      exp_t e;
      bit   prev_done;
      prev_done = 0;
      forever begin
         @(negedge CLK);
         if (prev_done) chk("done_pulse", DONE, 0);
         prev_done = DONE;
         if (DONE) begin
            dones++;
            if (sbq.size() == 0) begin
               tot_n++;
               $display("FAIL unexpected_done: got 1 want 0");
            end else begin
               e = sbq.pop_front();
               chk({e.nm, "_c1x"}, C1X, e.c1x);
               chk({e.nm, "_c1y"}, C1Y, e.c1y);
               chk({e.nm, "_c2x"}, C2X, e.c2x);
               chk({e.nm, "_c2y"}, C2Y, e.c2y);
               chk({e.nm, "_ncand"}, ncand, e.ncand);
               chk({e.nm, "_busy"}, busy, 0);
            end
         end
      end
   end

   task automatic chk_reset(string nm);
      chk({nm, "_c1x"}, C1X, 0);
      chk({nm, "_c1y"}, C1Y, 0);
      chk({nm, "_c2x"}, C2X, 0);
      chk({nm, "_c2y"}, C2Y, 0);
      chk({nm, "_done"}, DONE, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_cv"}, eng.cand_valid, 0);
      chk({nm, "_cand"}, {eng.cand_x, eng.cand_y}, 0);
      chk({nm, "_fix"}, {eng.fix_x, eng.fix_y}, 0);
   endtask

   task automatic kick(int m);
      mode = m;
      ncand = 0;
      stall_done = 1'b0;
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic run(int m, exp_t e);
      int d0;
      sbq.push_back(e);
      d0 = dones;
      kick(m);
      for (int i = 0; i < 5000 && dones == d0; i++) begin
         @(negedge CLK);
         start = (i == 50);
      end
      start = 1'b0;
      if (dones == d0) begin
         tot_n++;
         $display("FAIL %s_timeout: got no DONE want DONE", e.nm);
         sbq.delete();
      end
      repeat (3) @(negedge CLK);
   endtask

   initial begin : stim
      repeat (3) @(negedge CLK);
      chk_reset("rst");
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      run(0, '{"zero", 4, 4, 11, 11, 512});
      run(1, '{"const5", 0, 0, 11, 11, 1024});
      run(2, '{"peaks", 7, 3, 9, 12, 1024});
`ifdef LASER_EARLY_EXIT_EN
      run(3, '{"full", 2, 2, 11, 11, 35});
`else
      run(3, '{"full", 2, 2, 11, 11, 1024});
`endif
      run(4, '{"maxit", 0, 0, 0, 0, 2048});

      kick(4);
      repeat (700) @(negedge CLK);
      RST = 1'b1;
      #1;
      chk_reset("midrst");
      @(negedge CLK);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      run(1, '{"after_rst", 0, 0, 11, 11, 1024});

      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end

endmodule

// File: doc/laser_search_ctrl.md
# laser_search_ctrl

Search scheduler for the LASER two-circle coverage problem. After the 40-point set is loaded, it runs alternating passes that reposition circle 1 with circle 2 held fixed, then circle 2 with circle 1 held fixed. For each candidate center it issues a request to the shared coverage-count engine over a valid/ready handshake and keeps the best result. It stops on convergence or at an iteration limit, then presents the final centers and pulses DONE.

## Interface
Parameters:
- GRID_W, 4, coordinate width (16×16 grid)
- CNT_W, 6, coverage-count width
- NPTS, 40, number of points in the set
- MAX_ITER, 4, maximum number of rounds (one round = pass 1 + pass 2)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse after point load; ignored while busy
- busy  out  1  high from the cycle after an accepted start until DONE
- cand_valid  out  1  candidate request valid
- cand_ready  in  1  engine accepts candidate
- cand_x, cand_y  out  GRID_W  candidate center
- fix_x, fix_y  out  GRID_W  the other (fixed) circle's center
- res_valid  in  1  engine result strobe
- res_cnt  in  CNT_W  union coverage count for candidate + fixed circle
- C1X, C1Y, C2X, C2Y  out  GRID_W each  best-known centers
- DONE  out  1  one-cycle completion pulse

## Operation
- States: IDLE, INIT, SCAN, WAIT, PASS_END, FINISH.
- INIT:
  - C1 := (4,4), C2 := (11,11).
  - global_best := 0, iter := 0.
  - Select pass 1.
- Scan order: raster over the grid, y outer 0..15, x inner 0..15, starting at (0,0).
- SCAN:
  - Assert cand_valid with the current candidate.
  - fix_x/fix_y = C2 in pass 1, C1 in pass 2.
  - Move to WAIT on cand_valid && cand_ready.
- WAIT:
  - Wait for res_valid.
  - If res_cnt > pass_best (strict), record pass_best and pass_pos.
  - If the candidate was (15,15), go to PASS_END; otherwise advance the candidate and return to SCAN.
- pass_best is loaded with global_best at pass start. Ties keep the earlier candidate and the existing center.
- PASS_END:
  - If pass_best > global_best, update global_best, move the active circle (C1 or C2 register) to pass_pos, and set the round_improved flag.
  - After pass 1: go to pass 2.
  - After pass 2: increment iter.
    - If !round_improved or iter == MAX_ITER, go to FINISH.
    - Otherwise clear round_improved and start pass 1.
- FINISH: pulse DONE, go to IDLE.
- Protocol rules:
  - res_valid is ignored outside WAIT.
  - At most one request is outstanding.
  - cand_x/cand_y/fix_* are held stable while cand_valid && !cand_ready.
- Arithmetic: unsigned; candidate x wraps 15→0 with y+1; iter is sized to hold MAX_ITER.

## Timing
- Reset values: C1X=C1Y=C2X=C2Y=0, DONE=0, busy=0, cand_valid=0, cand_x=cand_y=fix_x=fix_y=0.
- start accepted in IDLE. INIT takes 1 cycle; the first cand_valid is high 2 cycles after the start edge.
- With a zero-stall engine (ready=1, result 1 cycle after acceptance):
  - 2 cycles per candidate.
  - 512 cycles per pass, plus 1 cycle for PASS_END.
- C1/C2 outputs change only in PASS_END and are final when DONE is high.
- DONE is high for exactly one cycle; busy falls in the same cycle.
- Boundary conditions:
  - start while busy: ignored.
  - res_valid in the same cycle as acceptance: ignored (the result must come ≥1 cycle later).
  - RST mid-pass: all outputs return to reset values immediately; any in-flight result is dropped.
  - All res_cnt = 0: round 1 yields no improvement → FINISH after one round with C1=(4,4), C2=(11,11).

## Configuration
- LASER_EARLY_EXIT_EN defined:
  - In WAIT, res_cnt == NPTS immediately commits the active circle to the candidate, sets global_best, and goes to FINISH.
  - The remaining candidates and passes are skipped.
- Not defined: a full count is treated as a normal improvement and the search runs to convergence.

## Structure
- Shared package laser_pkg holds:
  - state enum
  - GRID_W, CNT_W, NPTS
  - initial center constants (4,4) and (11,11)
- Natural sub-module: laser_raster_gen, a candidate x/y counter with advance, clear, and last-cell flag.

## Test plan
- Engine returns 5 for every candidate:
  - Pass 1 moves C1 to (0,0); pass 2 makes no change.
  - Round 2 shows no improvement, so DONE follows with C1=(0,0), C2=(11,11).
  - Total ≈ 4×513 cycles.
- Engine returns 10 only at (7,3) in pass 1 and 12 only at (9,12) in pass 2, 0 elsewhere → DONE with C1=(7,3), C2=(9,12) after round 2.
- cand_ready held low 3 cycles on candidate (5,0) → cand_x/cand_y/fix_* stable, no advance, no result accepted.
- res_cnt=40 at (2,2) in pass 1:
  - With LASER_EARLY_EXIT_EN: DONE within 3 cycles, C1=(2,2).
  - Without the macro: the search completes normally with the same C1.
- Engine returns pass_index+1 per pass (always improving) → DONE after exactly MAX_ITER=4 rounds.
- RST asserted mid pass 2 → all outputs 0 immediately; a fresh start completes normally.
